vga_scan_gen: RTL

- Parametrised successor to the single-mode VGA timing generator.
- Generates H/V timing from runtime config and issues pixel-address requests to an external frame buffer that has a fixed read latency.
- Adds sync polarity control, integer pixel scaling (1x/2x/4x), base/stride addressing without multipliers, latency-aligned outputs, and frame-boundary config shadowing.
- Sits between the frame-buffer read port and the DAC/pin driver.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_delay_line.sv | 32 +++
 rtl/vga_scan_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA scan generator.
//   scale_e      : pixel replication factor encoding on cfg_scale
//   vga_timing_t : one axis of timing (active / front porch / sync / back porch)
//   DEF_H/DEF_V  : 640x480@60 timing
//   scale_mask() : sub-pixel / sub-line counter wrap value for a scale code
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        SCALE_1X = 2'd0,
        SCALE_2X = 2'd1,
        SCALE_4X = 2'd2
    } scale_e;

    localparam int TIM_W = 16;

    typedef struct packed {
        logic [TIM_W-1:0] active;
        logic [TIM_W-1:0] fp;
        logic [TIM_W-1:0] sync;
        logic [TIM_W-1:0] bp;
    } vga_timing_t;

    localparam vga_timing_t DEF_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam vga_timing_t DEF_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

    // Counter wrap value: 2^scale - 1. The reserved code falls back to 1x.
    function automatic logic [1:0] scale_mask(input logic [1:0] s);
        if (s == SCALE_2X)      return 2'b01;
        else if (s == SCALE_4X) return 2'b11;
        else                    return 2'b00;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// WIDTH-bit shift register, DEPTH stages, synchronous active-low clear.
//   i_clk    : clock
//   i_srst_n : synchronous clear, active low
//   i_d      : input word
//   o_q      : input word delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_srst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// -----------------------------------------------------------------------------
// vga_scan_gen
// Runtime-configurable VGA timing generator that fetches pixels from a frame
// buffer with a fixed read latency and emits latency-aligned sync/de/rgb.
//   i_clk, i_srst_n        : pixel clock, synchronous active-low reset
//   i_enable               : 1 = fetch pixels, 0 = show i_cfg_clear in active area
//   i_cfg_h_* / i_cfg_v_*  : timing (pixels / lines), captured at frame wrap
//   i_cfg_hs/vs_pol        : 1 = sync pulse high
//   i_cfg_scale            : 0 = 1x, 1 = 2x, 2 = 4x, 3 = 1x
//   i_cfg_base/i_cfg_stride: frame base address, source line pitch
//   i_cfg_clear            : colour shown when fetching is disabled
//   o_req_valid/o_req_addr : frame-buffer read request (counter stage)
//   i_rd_data              : data for the request issued RD_LAT cycles earlier
//   o_hsync/o_vsync/o_de/o_rgb : outputs, RD_LAT+1 cycles after the request
//   o_frame_start/o_frame_end  : single-cycle pulses, counter stage
// -----------------------------------------------------------------------------
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_BITS    = 11,
    parameter int V_BITS    = 11,
    parameter int CHANNELS  = 3,
    parameter int CH_BITS   = 4,
    parameter int ADDR_BITS = 20,
    parameter int RD_LAT    = 2
) (
    input  logic                         i_clk,
    input  logic                         i_srst_n,
    input  logic                         i_enable,
    input  logic [H_BITS-1:0]            i_cfg_h_active,
    input  logic [H_BITS-1:0]            i_cfg_h_fp,
    input  logic [H_BITS-1:0]            i_cfg_h_sync,
    input  logic [H_BITS-1:0]            i_cfg_h_bp,
    input  logic [V_BITS-1:0]            i_cfg_v_active,
    input  logic [V_BITS-1:0]            i_cfg_v_fp,
    input  logic [V_BITS-1:0]            i_cfg_v_sync,
    input  logic [V_BITS-1:0]            i_cfg_v_bp,
    input  logic                         i_cfg_hs_pol,
    input  logic                         i_cfg_vs_pol,
    input  logic [1:0]                   i_cfg_scale,
    input  logic [ADDR_BITS-1:0]         i_cfg_base,
    input  logic [ADDR_BITS-1:0]         i_cfg_stride,
    input  logic [CHANNELS*CH_BITS-1:0]  i_cfg_clear,
    output logic                         o_req_valid,
    output logic [ADDR_BITS-1:0]         o_req_addr,
    input  logic [CHANNELS*CH_BITS-1:0]  i_rd_data,
    output logic                         o_hsync,
    output logic                         o_vsync,
    output logic                         o_de,
    output logic [CHANNELS*CH_BITS-1:0]  o_rgb,
    output logic                         o_frame_start,
    output logic                         o_frame_end
);

    localparam int HW = H_BITS + 2;
    localparam int VW = V_BITS + 2;
    localparam int PW = CHANNELS * CH_BITS;

    // Shadow configuration (frame-stable copy of i_cfg_*)
    logic [H_BITS-1:0]    r_h_act, r_h_fp, r_h_sync, r_h_bp;
    logic [V_BITS-1:0]    r_v_act, r_v_fp, r_v_sync, r_v_bp;
    logic                 r_hs_pol, r_vs_pol;
    logic [1:0]           r_scale_msk;
    logic [ADDR_BITS-1:0] r_stride;
    logic [PW-1:0]        r_clear;

    // Counter stage
    logic                 r_live;       // 0 during the reset cycle: counters parked at (0,0)
    logic                 r_en;
    logic [HW-1:0]        r_x;
    logic [VW-1:0]        r_y;
    logic [1:0]           r_xsub, r_ysub;
    logic [ADDR_BITS-1:0] r_pix_addr, r_line_base;

    // Output stage
    logic                 r_de, r_hsync, r_vsync;
    logic [PW-1:0]        r_rgb;

    logic [HW-1:0] w_hs_start, w_hs_end, w_h_total;
    logic [VW-1:0] w_vs_start, w_vs_end, w_v_total;
    logic          w_x_wrap, w_y_wrap, w_frame_wrap;
    logic          w_active, w_hs_act, w_vs_act;
    logic          w_tap_de, w_tap_hs, w_tap_vs, w_tap_en;

    assign w_hs_start = {2'b00, r_h_act} + {2'b00, r_h_fp};
    assign w_hs_end   = w_hs_start + {2'b00, r_h_sync};
    assign w_h_total  = w_hs_end + {2'b00, r_h_bp};
    assign w_vs_start = {2'b00, r_v_act} + {2'b00, r_v_fp};
    assign w_vs_end   = w_vs_start + {2'b00, r_v_sync};
    assign w_v_total  = w_vs_end + {2'b00, r_v_bp};

    assign w_x_wrap     = (r_x == w_h_total - HW'(1));
    assign w_y_wrap     = (r_y == w_v_total - VW'(1));
    assign w_frame_wrap = r_live && w_x_wrap && w_y_wrap;

    assign w_active = r_live && (r_x < {2'b00, r_h_act}) && (r_y < {2'b00, r_v_act});
    assign w_hs_act = r_live && (r_x >= w_hs_start) && (r_x < w_hs_end);
    assign w_vs_act = r_live && (r_y >= w_vs_start) && (r_y < w_vs_end);

    assign o_req_valid   = w_active && r_en;
    assign o_req_addr    = r_pix_addr;
    assign o_frame_start = r_live && (r_x == '0) && (r_y == '0);
    assign o_frame_end   = r_live && (r_x == {2'b00, r_h_act})
                                  && (r_y == {2'b00, r_v_act} - VW'(1));

    always_ff @(posedge i_clk) begin
        if (!i_srst_n || w_frame_wrap) begin
            r_h_act     <= i_cfg_h_active;
            r_h_fp      <= i_cfg_h_fp;
            r_h_sync    <= i_cfg_h_sync;
            r_h_bp      <= i_cfg_h_bp;
            r_v_act     <= i_cfg_v_active;
            r_v_fp      <= i_cfg_v_fp;
            r_v_sync    <= i_cfg_v_sync;
            r_v_bp      <= i_cfg_v_bp;
            r_hs_pol    <= i_cfg_hs_pol;
            r_vs_pol    <= i_cfg_vs_pol;
            r_scale_msk <= scale_mask(i_cfg_scale);
            r_stride    <= i_cfg_stride;
            r_clear     <= i_cfg_clear;
        end
    end

    // Base is only consumed at the capture moments (reset / frame wrap), so it
    // is taken straight from the input there instead of being shadowed.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            r_live      <= 1'b0;
            r_en        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_xsub      <= '0;
            r_ysub      <= '0;
            r_pix_addr  <= i_cfg_base;
            r_line_base <= i_cfg_base;
        end else begin
            r_live <= 1'b1;
            r_en   <= i_enable;
            if (r_live) begin
                if (w_x_wrap) begin
                    r_x    <= '0;
                    r_xsub <= '0;
                    if (w_y_wrap) begin
                        r_y         <= '0;
                        r_ysub      <= '0;
                        r_line_base <= i_cfg_base;
                        r_pix_addr  <= i_cfg_base;
                    end else begin
                        r_y <= r_y + VW'(1);
                        if (r_ysub == r_scale_msk) begin
                            r_ysub      <= '0;
                            r_line_base <= r_line_base + r_stride;
                            r_pix_addr  <= r_line_base + r_stride;
                        end else begin
                            r_ysub     <= r_ysub + 2'd1;
                            r_pix_addr <= r_line_base;
                        end
                    end
                end else begin
                    r_x <= r_x + HW'(1);
                    if (w_active) begin
                        if (r_xsub == r_scale_msk) begin
                            r_xsub     <= '0;
                            r_pix_addr <= r_pix_addr + ADDR_BITS'(1);
                        end else begin
                            r_xsub <= r_xsub + 2'd1;
                        end
                    end
                end
            end
        end
    end

    // RD_LAT stages here line the flags up with i_rd_data; the output
    // registers below add the final stage (RD_LAT+1 in total).
    vga_delay_line #(
        .WIDTH (4),
        .DEPTH (RD_LAT)
    ) u_align (
        .i_clk    (i_clk),
        .i_srst_n (i_srst_n),
        .i_d      ({w_active, w_hs_act, w_vs_act, r_en}),
        .o_q      ({w_tap_de, w_tap_hs, w_tap_vs, w_tap_en})
    );

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            r_de    <= 1'b0;
            r_rgb   <= '0;
            r_hsync <= ~i_cfg_hs_pol;
            r_vsync <= ~i_cfg_vs_pol;
        end else begin
            r_de    <= w_tap_de;
            r_rgb   <= w_tap_de ? (w_tap_en ? i_rd_data : r_clear) : '0;
            r_hsync <= w_tap_hs ? r_hs_pol : ~r_hs_pol;
            r_vsync <= w_tap_vs ? r_vs_pol : ~r_vs_pol;
        end
    end

    assign o_de    = r_de;
    assign o_rgb   = r_rgb;
    assign o_hsync = r_hsync;
    assign o_vsync = r_vsync;

endmodule
